// File: rtl/alu_issuer.sv
// ---------------------------------------------------------------------------
// alu_issuer
// Issues one operation at a time to an external fixed-latency ALU, waits
// LATENCY cycles, captures the result and flags, and holds them on a
// valid/ready response port until consumed. OP_CNT counts consumed responses.
// ---------------------------------------------------------------------------
module alu_issuer #(
    parameter int unsigned DWIDTH  = 16,
    parameter int unsigned OPWIDTH = 4,
    parameter int unsigned LATENCY = 2,
    parameter int unsigned IDLE_OP = 0
) (
    input  logic               clk_i,
    input  logic               clr_n_i,
    // request side
    input  logic               req_valid_i,
    output logic               req_ready_o,
    input  logic [DWIDTH-1:0]  req_a_i,
    input  logic [DWIDTH-1:0]  req_b_i,
    input  logic [OPWIDTH-1:0] req_op_i,
    // ALU side
    output logic [DWIDTH-1:0]  alu_a_o,
    output logic [DWIDTH-1:0]  alu_b_o,
    output logic [OPWIDTH-1:0] alu_s_o,
    input  logic [DWIDTH-1:0]  alu_y_i,
    input  logic               alu_c_i,
    input  logic               alu_v_i,
    input  logic               alu_z_i,
    // response side
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DWIDTH-1:0]  rsp_y_o,
    output logic [2:0]         rsp_flags_o,
    output logic [15:0]        op_cnt_o
);

    // Wait counter is 4 bits wide: LATENCY is limited to 1..15.
    localparam int unsigned CNT_W = 4;

    localparam logic [CNT_W-1:0]   LAT_LOAD = CNT_W'(LATENCY);
    localparam logic [OPWIDTH-1:0] IDLE_S   = OPWIDTH'(IDLE_OP);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    state_e              state_q;
    logic                req_ready_q;
    logic [DWIDTH-1:0]   alu_a_q;
    logic [DWIDTH-1:0]   alu_b_q;
    logic [OPWIDTH-1:0]  alu_s_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                rsp_valid_q;
    logic [DWIDTH-1:0]   rsp_y_q;
    logic [2:0]          rsp_flags_q;
    logic [15:0]         op_cnt_q;
    logic [15:0]         op_cnt_d;

    // Handshake counter next value; wraps naturally from 16'hFFFF to 16'h0000.
    always_comb begin
        op_cnt_d = op_cnt_q + 16'd1;
    end

    // Issue/wait/respond state machine with all outputs held in registers.
    always_ff @(posedge clk_i or negedge clr_n_i) begin
        if (!clr_n_i) begin
            state_q     <= ST_IDLE;
            req_ready_q <= 1'b1;
            alu_a_q     <= {DWIDTH{1'b0}};
            alu_b_q     <= {DWIDTH{1'b0}};
            alu_s_q     <= IDLE_S;
            cnt_q       <= {CNT_W{1'b0}};
            rsp_valid_q <= 1'b0;
            rsp_y_q     <= {DWIDTH{1'b0}};
            rsp_flags_q <= 3'b000;
            op_cnt_q    <= 16'd0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Ready is high in IDLE, so a valid request is accepted here.
                    if (req_valid_i) begin
                        alu_a_q     <= req_a_i;
                        alu_b_q     <= req_b_i;
                        alu_s_q     <= req_op_i;
                        cnt_q       <= LAT_LOAD;
                        req_ready_q <= 1'b0;
                        state_q     <= ST_WAIT;
                    end else begin
                        req_ready_q <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    // A counter at or below one means the ALU result is valid
                    // now; the "or below" guards against a corrupted zero count
                    // wrapping into a fifteen-cycle stall.
                    if (cnt_q <= 4'd1) begin
                        rsp_y_q     <= alu_y_i;
                        rsp_flags_q <= {alu_c_i, alu_v_i, alu_z_i};
                        rsp_valid_q <= 1'b1;
                        alu_s_q     <= IDLE_S;
                        cnt_q       <= {CNT_W{1'b0}};
                        state_q     <= ST_RESP;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_RESP: begin
                    // Response is held until the consumer takes it.
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        op_cnt_q    <= op_cnt_d;
                        req_ready_q <= 1'b1;
                        state_q     <= ST_IDLE;
                    end else begin
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    // Illegal encoding: drop any operation and return to IDLE.
                    state_q     <= ST_IDLE;
                    req_ready_q <= 1'b1;
                    rsp_valid_q <= 1'b0;
                    alu_s_q     <= IDLE_S;
                    cnt_q       <= {CNT_W{1'b0}};
                end
            endcase
        end
    end

    assign req_ready_o = req_ready_q;
    assign alu_a_o     = alu_a_q;
    assign alu_b_o     = alu_b_q;
    assign alu_s_o     = alu_s_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_y_o     = rsp_y_q;
    assign rsp_flags_o = rsp_flags_q;
    assign op_cnt_o    = op_cnt_q;

endmodule

// File: tb/tb_alu_issuer.sv
// ---------------------------------------------------------------------------
// tb_alu_issuer : directed self-checking bench for alu_issuer (LATENCY=2).
// A small combinational ALU model (add/sub/and) drives the ALU inputs; an
// override mode lets tests force arbitrary result and flag values.
// ---------------------------------------------------------------------------
module tb_alu_issuer;

    logic        clk_i = 1'b0;
    logic        clr_n_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic [15:0] req_a_i;
    logic [15:0] req_b_i;
    logic [3:0]  req_op_i;
    logic [15:0] alu_a_o;
    logic [15:0] alu_b_o;
    logic [3:0]  alu_s_o;
    logic [15:0] alu_y_i;
    logic        alu_c_i;
    logic        alu_v_i;
    logic        alu_z_i;
    logic        rsp_valid_o;
    logic        rsp_ready_i;
    logic [15:0] rsp_y_o;
    logic [2:0]  rsp_flags_o;
    logic [15:0] op_cnt_o;

    int checks   = 0;
    int failures = 0;

    // ALU model and override controls
    logic        ovr = 1'b0;
    logic [15:0] ovr_y = 16'd0;
    logic        ovr_c = 1'b0;
    logic        ovr_v = 1'b0;
    logic        ovr_z = 1'b0;
    logic [15:0] m_y;
    logic        m_c;
    logic        m_v;

    alu_issuer #(
        .DWIDTH (16),
        .OPWIDTH(4),
        .LATENCY(2),
        .IDLE_OP(0)
    ) dut (
        .clk_i      (clk_i),
        .clr_n_i    (clr_n_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_a_i    (req_a_i),
        .req_b_i    (req_b_i),
        .req_op_i   (req_op_i),
        .alu_a_o    (alu_a_o),
        .alu_b_o    (alu_b_o),
        .alu_s_o    (alu_s_o),
        .alu_y_i    (alu_y_i),
        .alu_c_i    (alu_c_i),
        .alu_v_i    (alu_v_i),
        .alu_z_i    (alu_z_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_ready_i(rsp_ready_i),
        .rsp_y_o    (rsp_y_o),
        .rsp_flags_o(rsp_flags_o),
        .op_cnt_o   (op_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    // Combinational ALU model: 1=add, 2=sub, 3=and, others give zero.
    always_comb begin
        m_y = 16'd0;
        m_c = 1'b0;
        m_v = 1'b0;
        case (alu_s_o)
            4'd1: begin
                {m_c, m_y} = {1'b0, alu_a_o} + {1'b0, alu_b_o};
                m_v = (alu_a_o[15] == alu_b_o[15]) && (m_y[15] != alu_a_o[15]);
            end
            4'd2: begin
                m_y = alu_a_o - alu_b_o;
                m_c = (alu_a_o < alu_b_o);
            end
            4'd3: m_y = alu_a_o & alu_b_o;
            default: m_y = 16'd0;
        endcase
    end

    assign alu_y_i = ovr ? ovr_y : m_y;
    assign alu_c_i = ovr ? ovr_c : m_c;
    assign alu_v_i = ovr ? ovr_v : m_v;
    assign alu_z_i = ovr ? ovr_z : (m_y == 16'd0);

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic test_reset();
        clr_n_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
        req_a_i = 16'd0; req_b_i = 16'd0; req_op_i = 4'd0;
        tick(); tick();
        checks++; if (req_ready_o !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", req_ready_o); end
        checks++; if (rsp_valid_o !== 1'b0) begin failures++; $display("FAIL reset_rsp_valid got=%0b exp=0", rsp_valid_o); end
        checks++; if (rsp_y_o !== 16'd0) begin failures++; $display("FAIL reset_rsp_y got=%h exp=0000", rsp_y_o); end
        checks++; if (rsp_flags_o !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", rsp_flags_o); end
        checks++; if (alu_a_o !== 16'd0 || alu_b_o !== 16'd0) begin failures++; $display("FAIL reset_alu_ab got=%h/%h exp=0000/0000", alu_a_o, alu_b_o); end
        checks++; if (alu_s_o !== 4'd0) begin failures++; $display("FAIL reset_alu_s got=%0d exp=0", alu_s_o); end
        checks++; if (op_cnt_o !== 16'd0) begin failures++; $display("FAIL reset_op_cnt got=%0d exp=0", op_cnt_o); end
    endtask

    // 3+5 accepted on the first edge after reset release
    task automatic test_basic();
        req_a_i = 16'd3; req_b_i = 16'd5; req_op_i = 4'd1; req_valid_i = 1'b1;
        clr_n_i = 1'b1;
        tick();  // acceptance edge
        req_valid_i = 1'b0;
        checks++; if (alu_s_o !== 4'd1 || alu_a_o !== 16'd3 || alu_b_o !== 16'd5) begin failures++; $display("FAIL basic_issue got=%0d,%0d,%0d exp=1,3,5", alu_s_o, alu_a_o, alu_b_o); end
        checks++; if (req_ready_o !== 1'b0) begin failures++; $display("FAIL basic_busy got=%0b exp=0", req_ready_o); end
        tick();
        checks++; if (rsp_valid_o !== 1'b0 || alu_s_o !== 4'd1) begin failures++; $display("FAIL basic_wait got=v%0b s%0d exp=v0 s1", rsp_valid_o, alu_s_o); end
        tick();  // capture edge
        checks++; if (rsp_valid_o !== 1'b1 || rsp_y_o !== 16'd8) begin failures++; $display("FAIL basic_capture got=v%0b y%0d exp=v1 y8", rsp_valid_o, rsp_y_o); end
        checks++; if (rsp_flags_o !== 3'b000 || alu_s_o !== 4'd0) begin failures++; $display("FAIL basic_flags_s got=%b s%0d exp=000 s0", rsp_flags_o, alu_s_o); end
        rsp_ready_i = 1'b1;
        tick();  // handshake
        rsp_ready_i = 1'b0;
        checks++; if (rsp_valid_o !== 1'b0 || op_cnt_o !== 16'd1 || req_ready_o !== 1'b1) begin failures++; $display("FAIL basic_handshake got=v%0b cnt%0d r%0b exp=v0 cnt1 r1", rsp_valid_o, op_cnt_o, req_ready_o); end
    endtask

    // Response held 10 cycles with RSP_READY low; new requests ignored
    task automatic test_hold();
        req_a_i = 16'd10; req_b_i = 16'd3; req_op_i = 4'd2; req_valid_i = 1'b1;
        tick();
        req_a_i = 16'hBEEF; req_b_i = 16'h1111; req_op_i = 4'd3;  // stays valid, must be ignored
        tick(); tick();
        for (int i = 0; i < 10; i++) begin
            checks++; if (rsp_valid_o !== 1'b1 || rsp_y_o !== 16'd7 || rsp_flags_o !== 3'b000) begin failures++; $display("FAIL hold_rsp cyc=%0d got=v%0b y%0d f%b exp=v1 y7 f000", i, rsp_valid_o, rsp_y_o, rsp_flags_o); end
            checks++; if (req_ready_o !== 1'b0 || alu_s_o !== 4'd0 || alu_a_o !== 16'd10) begin failures++; $display("FAIL hold_ignore cyc=%0d got=r%0b s%0d a%h exp=r0 s0 a000a", i, req_ready_o, alu_s_o, alu_a_o); end
            tick();
        end
        req_valid_i = 1'b0;
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        checks++; if (op_cnt_o !== 16'd2 || rsp_valid_o !== 1'b0) begin failures++; $display("FAIL hold_done got=cnt%0d v%0b exp=cnt2 v0", op_cnt_o, rsp_valid_o); end
    endtask

    // Five back-to-back adds with RSP_READY always high
    task automatic test_back_to_back();
        logic [15:0] ta [5] = '{16'd1, 16'd200, 16'hFFFF, 16'd7, 16'h1234};
        logic [15:0] tb [5] = '{16'd2, 16'd300, 16'd1, 16'd7, 16'h0101};
        logic [15:0] ty [5] = '{16'd3, 16'd500, 16'h0000, 16'd14, 16'h1335};
        int          acc_cyc [$];
        logic [15:0] got [$];
        int          idx = 0;
        logic        acc;
        logic        hs;
        logic [15:0] y;
        req_a_i = ta[0]; req_b_i = tb[0]; req_op_i = 4'd1; req_valid_i = 1'b1;
        rsp_ready_i = 1'b1;
        for (int cyc = 0; cyc < 60 && got.size() < 5; cyc++) begin
            acc = req_ready_o && req_valid_i;
            hs  = rsp_valid_o && rsp_ready_i;
            y   = rsp_y_o;
            tick();
            if (hs) got.push_back(y);
            if (acc) begin
                acc_cyc.push_back(cyc);
                idx++;
                if (idx < 5) begin
                    req_a_i = ta[idx]; req_b_i = tb[idx];
                end else begin
                    req_valid_i = 1'b0;
                end
            end
        end
        rsp_ready_i = 1'b0;
        checks++; if (got.size() != 5 || acc_cyc.size() != 5) begin failures++; $display("FAIL b2b_count got=%0d/%0d exp=5/5", got.size(), acc_cyc.size()); end
        for (int i = 0; i < 5; i++) begin
            if (i < got.size()) begin
                checks++; if (got[i] !== ty[i]) begin failures++; $display("FAIL b2b_result idx=%0d got=%h exp=%h", i, got[i], ty[i]); end
            end
            if (i > 0 && i < acc_cyc.size()) begin
                checks++; if (acc_cyc[i] - acc_cyc[i-1] != 4) begin failures++; $display("FAIL b2b_interval idx=%0d got=%0d exp=4", i, acc_cyc[i] - acc_cyc[i-1]); end
            end
        end
        checks++; if (op_cnt_o !== 16'd7) begin failures++; $display("FAIL b2b_op_cnt got=%0d exp=7", op_cnt_o); end
    endtask

    // Reset pulse during WAIT abandons the operation; next one completes
    task automatic test_reset_wait();
        req_a_i = 16'd4; req_b_i = 16'd4; req_op_i = 4'd1; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();  // in WAIT
        clr_n_i = 1'b0;
        #2;
        checks++; if (alu_s_o !== 4'd0 || rsp_valid_o !== 1'b0 || op_cnt_o !== 16'd0) begin failures++; $display("FAIL rst_async got=s%0d v%0b cnt%0d exp=s0 v0 cnt0", alu_s_o, rsp_valid_o, op_cnt_o); end
        clr_n_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (rsp_valid_o !== 1'b0 || req_ready_o !== 1'b1) begin failures++; $display("FAIL rst_abandon cyc=%0d got=v%0b r%0b exp=v0 r1", i, rsp_valid_o, req_ready_o); end
        end
        req_a_i = 16'd20; req_b_i = 16'd22; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick(); tick();
        checks++; if (rsp_valid_o !== 1'b1 || rsp_y_o !== 16'd42) begin failures++; $display("FAIL rst_next got=v%0b y%0d exp=v1 y42", rsp_valid_o, rsp_y_o); end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        checks++; if (op_cnt_o !== 16'd1) begin failures++; $display("FAIL rst_next_cnt got=%0d exp=1", op_cnt_o); end
    endtask

    // Flags captured only on the capture edge; later ALU changes ignored
    task automatic test_flags();
        ovr = 1'b1; ovr_y = 16'h1111; ovr_c = 1'b0; ovr_v = 1'b1; ovr_z = 1'b0;
        req_a_i = 16'd9; req_b_i = 16'd9; req_op_i = 4'd3; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        ovr_y = 16'h0055; ovr_c = 1'b1; ovr_v = 1'b0; ovr_z = 1'b1;
        tick();  // capture edge
        ovr_y = 16'hFFFF; ovr_c = 1'b0; ovr_v = 1'b1; ovr_z = 1'b0;
        checks++; if (rsp_flags_o !== 3'b101 || rsp_y_o !== 16'h0055) begin failures++; $display("FAIL flags_capture got=%b y%h exp=101 y0055", rsp_flags_o, rsp_y_o); end
        tick(); tick();
        checks++; if (rsp_flags_o !== 3'b101 || rsp_y_o !== 16'h0055) begin failures++; $display("FAIL flags_stable got=%b y%h exp=101 y0055", rsp_flags_o, rsp_y_o); end
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        ovr = 1'b0;
        checks++; if (op_cnt_o !== 16'd2) begin failures++; $display("FAIL flags_cnt got=%0d exp=2", op_cnt_o); end
    endtask

    // RSP_READY high before the response exists must not drop anything
    task automatic test_early_ready();
        rsp_ready_i = 1'b1;
        req_a_i = 16'd50; req_b_i = 16'd8; req_op_i = 4'd2; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick();
        checks++; if (op_cnt_o !== 16'd2 || rsp_valid_o !== 1'b0) begin failures++; $display("FAIL early_wait got=cnt%0d v%0b exp=cnt2 v0", op_cnt_o, rsp_valid_o); end
        tick();
        checks++; if (rsp_valid_o !== 1'b1 || rsp_y_o !== 16'd42) begin failures++; $display("FAIL early_rsp got=v%0b y%0d exp=v1 y42", rsp_valid_o, rsp_y_o); end
        tick();
        rsp_ready_i = 1'b0;
        checks++; if (op_cnt_o !== 16'd3 || rsp_valid_o !== 1'b0) begin failures++; $display("FAIL early_done got=cnt%0d v%0b exp=cnt3 v0", op_cnt_o, rsp_valid_o); end
    endtask

    // Counter wrap: preload FFFF, one more handshake gives 0000
    task automatic test_wrap();
        force dut.op_cnt_q = 16'hFFFF;
        #1;
        release dut.op_cnt_q;
        req_a_i = 16'd1; req_b_i = 16'd1; req_op_i = 4'd1; req_valid_i = 1'b1;
        tick();
        req_valid_i = 1'b0;
        tick(); tick();
        rsp_ready_i = 1'b1;
        tick();
        rsp_ready_i = 1'b0;
        checks++; if (op_cnt_o !== 16'h0000) begin failures++; $display("FAIL wrap got=%h exp=0000", op_cnt_o); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_back_to_back();
        test_reset_wait();
        test_flags();
        test_early_ready();
        test_wrap();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
